// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight control-flow instructions: allocate at dispatch,
// resolve by tag from the branch unit, retire in order and feed fetch's predictor/RAS.
module branch_resolve_queue #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned TAG_W     = 3,
   parameter int unsigned RAS_PTR_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 alloc_valid,
   input  logic [31:0]          alloc_pc,
   input  logic                 alloc_prediction,
   input  logic [31:0]          alloc_pred_target,
   input  logic                 alloc_jalr,
   input  logic [RAS_PTR_W-1:0] alloc_ras_ptr,
   output logic [TAG_W-1:0]     alloc_tag,
   output logic                 full,
   input  logic                 res_valid,
   input  logic [TAG_W-1:0]     res_tag,
   input  logic                 res_taken,
   input  logic [31:0]          res_target,
   input  logic                 commit_ready,
   output logic                 head_resolved,
   input  logic                 exc_flush,
   output logic                 update,
   output logic                 valid_in,
   output logic [31:0]          committed_pc,
   output logic [31:0]          pc_update,
   output logic                 mispredicted,
   output logic [RAS_PTR_W-1:0] flush_ptr
);

   localparam int unsigned CNT_W = TAG_W + 1;

   logic [TAG_W-1:0]     r_head;
   logic [TAG_W-1:0]     r_tail;
   logic [CNT_W-1:0]     r_count;
   logic [DEPTH-1:0]     r_valid;
   logic [DEPTH-1:0]     r_resolved;
   logic [DEPTH-1:0]     r_taken;
   logic [DEPTH-1:0]     r_pred;
   logic [DEPTH-1:0]     r_jalr;
   logic [31:0]          r_pc          [DEPTH];
   logic [31:0]          r_pred_target [DEPTH];
   logic [31:0]          r_target      [DEPTH];
   logic [RAS_PTR_W-1:0] r_ras_ptr     [DEPTH];

   logic                 r_update;
   logic                 r_valid_in;
   logic [31:0]          r_committed_pc;
   logic [31:0]          r_pc_update;
   logic                 r_mispredicted;
   logic [RAS_PTR_W-1:0] r_flush_ptr;

   logic        w_head_resolved;
   logic        w_full;
   logic        w_commit;
   logic        w_eff_taken;
   logic        w_mispredict;
   logic        w_flush;
   logic        w_alloc;
   logic        w_res;
   logic [31:0] w_h_target;
   logic [31:0] w_h_pred_target;
   logic [31:0] w_h_pc;

   assign w_h_target      = r_target[r_head];
   assign w_h_pred_target = r_pred_target[r_head];
   assign w_h_pc          = r_pc[r_head];

   assign w_full          = (r_count == CNT_W'(DEPTH));
   assign w_head_resolved = r_valid[r_head] & r_resolved[r_head];
   assign w_commit        = commit_ready & w_head_resolved;

   // jalr always redirects, so only its target can be wrong
   assign w_eff_taken  = r_taken[r_head] | r_jalr[r_head];
   assign w_mispredict = r_jalr[r_head] ? (w_h_target != w_h_pred_target)
                       : ((r_taken[r_head] != r_pred[r_head]) ||
                          (r_taken[r_head] && (w_h_target != w_h_pred_target)));

   assign w_flush = (w_commit & w_mispredict) | exc_flush;
   assign w_alloc = alloc_valid & ~w_full & ~w_flush;
   assign w_res   = res_valid & r_valid[res_tag] & ~w_flush;

   // Pointers, occupancy, status bits and registered commit outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_head         <= '0;
         r_tail         <= '0;
         r_count        <= '0;
         r_valid        <= '0;
         r_resolved     <= '0;
         r_update       <= 1'b0;
         r_valid_in     <= 1'b0;
         r_committed_pc <= '0;
         r_pc_update    <= '0;
         r_mispredicted <= 1'b0;
         r_flush_ptr    <= '0;
      end else begin
         if (w_flush) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_valid    <= '0;
            r_resolved <= '0;
         end else begin
            if (w_commit) begin
               r_valid[r_head] <= 1'b0;
               r_head          <= r_head + TAG_W'(1);
            end
            if (w_res) r_resolved[res_tag] <= 1'b1;
            if (w_alloc) begin
               r_valid[r_tail]    <= 1'b1;
               r_resolved[r_tail] <= 1'b0;
               r_tail             <= r_tail + TAG_W'(1);
            end
            r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_commit);
         end

         r_valid_in     <= w_commit;
         r_mispredicted <= w_commit & w_mispredict;
         if (w_commit) begin
            r_update       <= w_eff_taken;
            r_committed_pc <= w_h_pc;
            r_pc_update    <= w_eff_taken ? w_h_target : w_h_pc + 32'd4;
            r_flush_ptr    <= r_ras_ptr[r_head];
         end
      end
   end

   // Entry payload storage; status bits above qualify it
   always_ff @(posedge clk) begin
      if (w_alloc) begin
         r_pc[r_tail]          <= alloc_pc;
         r_pred[r_tail]        <= alloc_prediction;
         r_pred_target[r_tail] <= alloc_pred_target;
         r_jalr[r_tail]        <= alloc_jalr;
         r_ras_ptr[r_tail]     <= alloc_ras_ptr;
      end
      if (w_res) begin
         r_taken[res_tag]  <= res_taken;
         r_target[res_tag] <= res_target;
      end
   end

   assign alloc_tag     = r_tail;
   assign full          = w_full;
   assign head_resolved = w_head_resolved;
   assign update        = r_update;
   assign valid_in      = r_valid_in;
   assign committed_pc  = r_committed_pc;
   assign pc_update     = r_pc_update;
   assign mispredicted  = r_mispredicted;
   assign flush_ptr     = r_flush_ptr;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue: queue-based reference model predicts
// every commit; a monitor checks each valid_in pulse against the expected record.
module tb_branch_resolve_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        alloc_valid;
   logic [31:0] alloc_pc;
   logic        alloc_prediction;
   logic [31:0] alloc_pred_target;
   logic        alloc_jalr;
   logic [3:0]  alloc_ras_ptr;
   logic [2:0]  alloc_tag;
   logic        full;
   logic        res_valid;
   logic [2:0]  res_tag;
   logic        res_taken;
   logic [31:0] res_target;
   logic        commit_ready;
   logic        head_resolved;
   logic        exc_flush;
   logic        update;
   logic        valid_in;
   logic [31:0] committed_pc;
   logic [31:0] pc_update;
   logic        mispredicted;
   logic [3:0]  flush_ptr;

   branch_resolve_queue #(.DEPTH(8), .TAG_W(3), .RAS_PTR_W(4)) dut (
      .clk(clk), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_prediction(alloc_prediction),
      .alloc_pred_target(alloc_pred_target), .alloc_jalr(alloc_jalr), .alloc_ras_ptr(alloc_ras_ptr),
      .alloc_tag(alloc_tag), .full(full),
      .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken), .res_target(res_target),
      .commit_ready(commit_ready), .head_resolved(head_resolved), .exc_flush(exc_flush),
      .update(update), .valid_in(valid_in), .committed_pc(committed_pc), .pc_update(pc_update),
      .mispredicted(mispredicted), .flush_ptr(flush_ptr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc, pred_target, target;
      logic        pred, jalr, taken, resolved;
      logic [3:0]  ras;
      logic [2:0]  tag;
   } ent_t;

   typedef struct {
      int          cyc;
      logic        upd, mis;
      logic [31:0] cpc, pcu;
      logic [3:0]  fp;
   } exp_t;

   typedef struct {
      logic        av;
      logic [31:0] apc;
      logic        ap;
      logic [31:0] apt;
      logic        aj;
      logic [3:0]  ar;
      logic        rv;
      logic [2:0]  rt;
      logic        rk;
      logic [31:0] rtg;
      logic        cr, ef;
   } stim_t;

   ent_t       mq[$];
   exp_t       sb[$];
   logic [2:0] mtail = '0;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Monitor: every commit pulse must match the oldest predicted commit
   always @(negedge clk) begin
      if (valid_in === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid_in", 32'(valid_in), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("commit_cycle", 32'(cyc), 32'(e.cyc));
            chk("update", 32'(update), 32'(e.upd));
            chk("committed_pc", committed_pc, e.cpc);
            chk("pc_update", pc_update, e.pcu);
            chk("mispredicted", 32'(mispredicted), 32'(e.mis));
            chk("flush_ptr", 32'(flush_ptr), 32'(e.fp));
         end
      end else if (mispredicted === 1'b1) begin
         chk("mispredict_without_commit", 32'(mispredicted), 32'd0);
      end
   end

   function automatic stim_t idle();
      stim_t s;
      s = '{av: 1'b0, apc: '0, ap: 1'b0, apt: '0, aj: 1'b0, ar: '0,
            rv: 1'b0, rt: '0, rk: 1'b0, rtg: '0, cr: 1'b0, ef: 1'b0};
      return s;
   endfunction

   function automatic int first_unres();
      for (int i = 0; i < mq.size(); i++) if (!mq[i].resolved) return i;
      return -1;
   endfunction

   // One cycle: check status outputs, drive inputs, advance model; called at a negedge
   task automatic step(input stim_t s);
      int   sz0;
      logic com, mis, fl;
      chk("full", 32'(full), 32'(mq.size() == 8));
      chk("alloc_tag", 32'(alloc_tag), 32'(mtail));
      chk("head_resolved", 32'(head_resolved), 32'(mq.size() > 0 && mq[0].resolved));
      alloc_valid = s.av; alloc_pc = s.apc; alloc_prediction = s.ap;
      alloc_pred_target = s.apt; alloc_jalr = s.aj; alloc_ras_ptr = s.ar;
      res_valid = s.rv; res_tag = s.rt; res_taken = s.rk; res_target = s.rtg;
      commit_ready = s.cr; exc_flush = s.ef;

      sz0 = mq.size();
      com = s.cr && sz0 > 0 && mq[0].resolved;
      mis = 1'b0;
      if (com) begin
         ent_t e;
         exp_t x;
         logic tk;
         e = mq.pop_front();
         tk = e.jalr | e.taken;
         if (e.jalr) mis = (e.target != e.pred_target);
         else        mis = (e.taken != e.pred) || (e.taken && e.target != e.pred_target);
         x.cyc = cyc + 1; x.upd = tk; x.mis = mis; x.cpc = e.pc;
         x.pcu = tk ? e.target : e.pc + 32'd4; x.fp = e.ras;
         sb.push_back(x);
      end
      fl = (com && mis) || s.ef;
      if (fl) begin
         mq.delete();
         mtail = '0;
      end else begin
         if (s.rv) begin
            for (int i = 0; i < mq.size(); i++) begin
               if (mq[i].tag == s.rt) begin
                  ent_t t;
                  t = mq[i];
                  t.resolved = 1'b1; t.taken = s.rk; t.target = s.rtg;
                  mq[i] = t;
               end
            end
         end
         if (s.av && sz0 < 8) begin
            ent_t n;
            n = '{pc: s.apc, pred_target: s.apt, target: '0, pred: s.ap, jalr: s.aj,
                  taken: 1'b0, resolved: 1'b0, ras: s.ar, tag: mtail};
            mq.push_back(n);
            mtail = mtail + 3'd1;
         end
      end
      @(negedge clk);
   endtask

   task automatic alloc(input logic [31:0] pc, input logic p, input logic [31:0] pt,
                        input logic j, input logic [3:0] r);
      stim_t s;
      s = idle();
      s.av = 1'b1; s.apc = pc; s.ap = p; s.apt = pt; s.aj = j; s.ar = r;
      step(s);
   endtask

   task automatic resolve(input logic [2:0] t, input logic k, input logic [31:0] tg,
                          input logic cr);
      stim_t s;
      s = idle();
      s.rv = 1'b1; s.rt = t; s.rk = k; s.rtg = tg; s.cr = cr;
      step(s);
   endtask

   task automatic commit_cyc();
      stim_t s;
      s = idle();
      s.cr = 1'b1;
      step(s);
   endtask

   task automatic check_reset_outputs();
      chk("rst_valid_in", 32'(valid_in), 32'd0);
      chk("rst_update", 32'(update), 32'd0);
      chk("rst_committed_pc", committed_pc, 32'd0);
      chk("rst_pc_update", pc_update, 32'd0);
      chk("rst_mispredicted", 32'(mispredicted), 32'd0);
      chk("rst_flush_ptr", 32'(flush_ptr), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_head_resolved", 32'(head_resolved), 32'd0);
   endtask

   initial begin
      stim_t s;
      int    idx;
      reset = 1'b0;
      s = idle();
      alloc_valid = 0; alloc_pc = 0; alloc_prediction = 0; alloc_pred_target = 0;
      alloc_jalr = 0; alloc_ras_ptr = 0; res_valid = 0; res_tag = 0; res_taken = 0;
      res_target = 0; commit_ready = 0; exc_flush = 0;
      repeat (2) @(negedge clk);
      check_reset_outputs();
      reset = 1'b1;
      @(negedge clk);

      // Correctly predicted not-taken branch
      alloc(32'h100, 1'b0, 32'h140, 1'b0, 4'd0);
      resolve(3'd0, 1'b0, 32'h0, 1'b0);
      commit_cyc();
      step(idle());

      // Mispredict; an allocate in the flush cycle is discarded
      alloc(32'h200, 1'b0, 32'h240, 1'b0, 4'd5);
      resolve(mq[0].tag, 1'b1, 32'h300, 1'b0);
      s = idle(); s.cr = 1'b1; s.av = 1'b1; s.apc = 32'h999;
      step(s);
      step(idle());

      // jalr target wrong, then right
      alloc(32'h40, 1'b1, 32'h80, 1'b1, 4'd2);
      resolve(mq[0].tag, 1'b1, 32'h90, 1'b0);
      commit_cyc();
      alloc(32'h40, 1'b1, 32'h80, 1'b1, 4'd3);
      resolve(mq[0].tag, 1'b1, 32'h80, 1'b0);
      commit_cyc();
      step(idle());

      // Fill, overflow attempt, commit-while-allocate, then stream 20 entries
      for (int i = 0; i < 9; i++) alloc(32'h1000 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 4'(i));
      resolve(mq[0].tag, 1'b0, 32'h0, 1'b0);
      s = idle(); s.cr = 1'b1; s.av = 1'b1; s.apc = 32'h2000;
      step(s);
      for (int i = 0; i < 40; i++) begin
         s = idle();
         s.cr = 1'b1;
         s.av = (i < 20); s.apc = 32'h3000 + 32'(i * 4); s.ar = 4'(i);
         idx = first_unres();
         if (idx >= 0) begin s.rv = 1'b1; s.rt = mq[idx].tag; end
         step(s);
      end

      // Out-of-order resolve, in-order commit; same-cycle resolve delays commit
      s = idle(); s.ef = 1'b1; step(s);
      for (int i = 0; i < 3; i++) alloc(32'h500 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 4'(i));
      resolve(3'd2, 1'b0, 32'h0, 1'b1);
      resolve(3'd0, 1'b0, 32'h0, 1'b1);
      resolve(3'd1, 1'b0, 32'h0, 1'b1);
      commit_cyc();
      commit_cyc();
      alloc(32'h600, 1'b0, 32'h0, 1'b0, 4'd9);
      resolve(mq[0].tag, 1'b0, 32'h0, 1'b1);
      commit_cyc();
      step(idle());

      // Reset mid-operation with 3 entries
      for (int i = 0; i < 3; i++) alloc(32'h700 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 4'(i));
      resolve(mq[0].tag, 1'b0, 32'h0, 1'b1);
      #2 reset = 1'b0;
      #1 check_reset_outputs();
      mq.delete();
      mtail = '0;
      #1 reset = 1'b1;
      @(negedge clk);

      // Exception flush with pending entries
      for (int i = 0; i < 3; i++) alloc(32'h800 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 4'(i));
      resolve(mq[1].tag, 1'b1, 32'h0, 1'b0);
      s = idle(); s.ef = 1'b1; step(s);
      step(idle());
      step(idle());

      // Randomised traffic
      for (int n = 0; n < 3000; n++) begin
         s = idle();
         s.av  = ($urandom_range(0, 9) < 7);
         s.apc = $urandom & 32'hFFFF_FFFC;
         s.aj  = ($urandom_range(0, 4) == 0);
         s.ap  = s.aj ? 1'b1 : 1'($urandom);
         s.apt = $urandom & 32'hFFFF_FFFC;
         s.ar  = 4'($urandom);
         s.rv  = ($urandom_range(0, 9) < 6);
         if (mq.size() > 0 && $urandom_range(0, 9) < 8) begin
            idx   = $urandom_range(0, mq.size() - 1);
            s.rt  = mq[idx].tag;
            s.rk  = mq[idx].jalr ? 1'b1
                  : (($urandom_range(0, 99) < 95) ? mq[idx].pred : ~mq[idx].pred);
            s.rtg = ($urandom_range(0, 99) < 95) ? mq[idx].pred_target
                  : ($urandom & 32'hFFFF_FFFC);
         end else begin
            s.rt  = 3'($urandom);
            s.rk  = 1'($urandom);
            s.rtg = $urandom;
         end
         s.cr = ($urandom_range(0, 9) < 7);
         s.ef = ($urandom_range(0, 199) == 0);
         step(s);
      end
      step(idle());
      step(idle());
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
